// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined chunked adder/subtractor with valid/ready on both sides
// Each stage adds one CW-bit chunk and hands its carry to the next; flags are formed in the last stage.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_res [STAGES];
  logic             r_cy  [STAGES];
  logic             r_vld [STAGES];
  logic             r_ovf;
  logic             r_zero;

  logic [WIDTH-1:0] w_a_in   [STAGES];
  logic [WIDTH-1:0] w_b_in   [STAGES];
  logic [WIDTH-1:0] w_res_in [STAGES];
  logic [WIDTH-1:0] w_res_nx [STAGES];
  logic             w_c_in   [STAGES];
  logic             w_v_in   [STAGES];
  logic [CW:0]      w_sum    [STAGES];
  logic             w_advance;
  logic             w_ovf;
  logic             w_unused_skew;

  // The whole pipe moves together, so a stalled output freezes bubbles too.
  assign w_advance = ~r_vld[LAST] | out_ready;
  assign in_ready  = w_advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CW{1'b1}}) << (k * CW);

    if (k == 0) begin : g_src
      assign w_a_in[k]   = a;
      assign w_b_in[k]   = sub ? ~b : b;
      assign w_c_in[k]   = sub;
      assign w_v_in[k]   = in_valid;
      assign w_res_in[k] = '0;
    end else begin : g_src
      assign w_a_in[k]   = r_a[k-1];
      assign w_b_in[k]   = r_b[k-1];
      assign w_c_in[k]   = r_cy[k-1];
      assign w_v_in[k]   = r_vld[k-1];
      assign w_res_in[k] = r_res[k-1];
    end

    assign w_sum[k] = {1'b0, w_a_in[k][k*CW +: CW]}
                    + {1'b0, w_b_in[k][k*CW +: CW]}
                    + {{CW{1'b0}}, w_c_in[k]};

    assign w_res_nx[k] = (w_res_in[k] & ~CHUNK_MASK)
                       | (WIDTH'(w_sum[k][CW-1:0]) << (k * CW));
  end

  // Sign bits of a and b_eff travel in the skew registers up to the last stage.
  assign w_ovf = (w_a_in[LAST][WIDTH-1] == w_b_in[LAST][WIDTH-1])
              && (w_res_nx[LAST][WIDTH-1] != w_a_in[LAST][WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_res[k] <= '0;
        r_cy[k]  <= 1'b0;
        r_vld[k] <= 1'b0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_res[k] <= w_res_nx[k];
        r_cy[k]  <= w_sum[k][CW];
        r_vld[k] <= w_v_in[k];
      end
      r_ovf  <= w_ovf;
      r_zero <= ~|w_res_nx[LAST];
    end
  end

  assign w_unused_skew = ^{r_a[LAST], r_b[LAST]};

  assign out_valid = r_vld[LAST];
  assign out       = r_res[LAST];
  assign carryOut  = r_cy[LAST];
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule
